// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Instruction-fetch sequencer driving the PC command pair
//            {LOAD_PC, INC_PC} and the PC load value ADDRESS.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int WORD_SIZE   = 19,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 HALT_REQ,
  input  logic                 BRANCH_REQ,
  input  logic [WORD_SIZE-1:0] BRANCH_TARGET,
  input  logic                 STALL,
  input  logic                 IMEM_READY,
  output logic                 LOAD_PC,
  output logic                 INC_PC,
  output logic [WORD_SIZE-1:0] ADDRESS,
  output logic                 FETCH_REQ,
  output logic                 HALTED,
  output logic                 FAULT,
  output logic [2:0]           STATE_O
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_DECIDE     = 3'd2,
    S_ISSUE_INC  = 3'd3,
    S_ISSUE_LOAD = 3'd4,
    S_SETTLE     = 3'd5,
    S_HALTED     = 3'd6,
    S_FAULT      = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(MEM_TIMEOUT);

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 load_q, load_d;
  logic                 inc_q, inc_d;
  logic                 fetch_q, fetch_d;
  logic                 halted_q, halted_d;
  logic                 fault_q, fault_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state selection, followed by the Moore outputs of the state being entered
  // so that every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        // A ready arriving on the last allowed cycle still wins over the timeout.
        if (IMEM_READY) begin
          state_d = S_DECIDE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == C_TIMEOUT) begin
            state_d = S_FAULT;
          end
        end
      end
      S_DECIDE: begin
        if (HALT_REQ) begin
          state_d = S_HALTED;
        end else if (BRANCH_REQ) begin
          state_d = S_ISSUE_LOAD;
          addr_d  = BRANCH_TARGET;
        end else if (!STALL) begin
          state_d = S_ISSUE_INC;
        end
      end
      S_ISSUE_INC,
      S_ISSUE_LOAD: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // One extra cycle lets the PC's execadd catch up with its temp register.
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_HALTED: begin
        if (START) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    load_d   = 1'b1;
    inc_d    = 1'b1;
    fetch_d  = 1'b0;
    halted_d = 1'b0;
    fault_d  = 1'b0;
    case (state_d)
      S_IDLE: begin
        load_d = 1'b0;
        inc_d  = 1'b0;
      end
      S_ISSUE_INC:  load_d   = 1'b0;
      S_ISSUE_LOAD: inc_d    = 1'b0;
      S_FETCH:      fetch_d  = 1'b1;
      S_HALTED:     halted_d = 1'b1;
      S_FAULT:      fault_d  = 1'b1;
      default: begin
        load_d = 1'b1;
        inc_d  = 1'b1;
      end
    endcase
  end

  // State, branch address, timeout counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      inc_q    <= 1'b0;
      fetch_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      inc_q    <= inc_d;
      fetch_q  <= fetch_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign LOAD_PC   = load_q;
  assign INC_PC    = inc_q;
  assign ADDRESS   = addr_q;
  assign FETCH_REQ = fetch_q;
  assign HALTED    = halted_q;
  assign FAULT     = fault_q;
  assign STATE_O   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Self-checking bench for pc_sequencer with a fetch-level reference
//            model and a behavioural program-counter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int WS = 19;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          halt_req = 1'b0;
  logic          branch_req = 1'b0;
  logic [WS-1:0] branch_target = '0;
  logic          stall = 1'b0;
  logic          imem_ready = 1'b0;
  logic          load_pc, inc_pc, fetch_req, halted, fault;
  logic [WS-1:0] address;
  logic [2:0]    state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: fetch-level view of where the sequencer should be.
  int            m_state = 0;
  int            m_cnt   = 0;
  logic [WS-1:0] m_addr  = '0;
  logic [WS-1:0] m_pc    = '0;   // address that the next fetch must see

  // Behavioural program counter driven by the DUT commands.
  logic [WS-1:0] pc_temp, execadd;

  pc_sequencer dut (
    .CLK(clk), .RST(rst), .START(start), .HALT_REQ(halt_req),
    .BRANCH_REQ(branch_req), .BRANCH_TARGET(branch_target), .STALL(stall),
    .IMEM_READY(imem_ready), .LOAD_PC(load_pc), .INC_PC(inc_pc),
    .ADDRESS(address), .FETCH_REQ(fetch_req), .HALTED(halted),
    .FAULT(fault), .STATE_O(state_o)
  );

  always #5 clk = ~clk;

  // PC: temp follows the command, execadd lags temp by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_temp <= '0;
      execadd <= '0;
    end else begin
      case ({load_pc, inc_pc})
        2'b00:   pc_temp <= '0;
        2'b10:   pc_temp <= address;
        2'b01:   pc_temp <= pc_temp + 1'b1;
        default: pc_temp <= pc_temp;
      endcase
      execadd <= pc_temp;
    end
  end

  wire [26:0] obs_vec = {state_o, load_pc, inc_pc, fetch_req, halted, fault, address};

  function automatic logic [26:0] exp_vec();
    logic [1:0] cmd;
    cmd = (m_state == 0) ? 2'b00 : (m_state == 3) ? 2'b01 : (m_state == 4) ? 2'b10 : 2'b11;
    return {3'(m_state), cmd, m_state == 1, m_state == 6, m_state == 7, m_addr};
  endfunction

  // Advance the model by the spec rules using the current inputs, then clock.
  task automatic step();
    int            ns = m_state;
    int            nc = m_cnt;
    logic [WS-1:0] na = m_addr;
    logic [WS-1:0] np = m_pc;
    if (rst) begin
      ns = 0; nc = 0; na = '0; np = '0;
    end else begin
      case (m_state)
        0, 6: if (start) begin ns = 1; nc = 0; end
        1: begin
          if (imem_ready) ns = 2;
          else begin
            nc = m_cnt + 1;
            if (nc == TMO) ns = 7;
          end
        end
        2: begin
          if (halt_req) ns = 6;
          else if (branch_req) begin ns = 4; na = branch_target; np = branch_target; end
          else if (!stall) begin ns = 3; np = m_pc + 1'b1; end
        end
        3, 4: ns = 5;
        5: begin ns = 1; nc = 0; end
        default: ns = 7;
      endcase
    end
    @(posedge clk);
    #1;
    m_state = ns; m_cnt = nc; m_addr = na; m_pc = np;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; start = 1'b0; halt_req = 1'b0; branch_req = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL reset: got %h exp %h", obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_inc_sequence();
    clear_inputs(); imem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(); start = 1'b0;
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL inc_seq cyc %0d: got %h exp %h", i, obs_vec, exp_vec());
      end
      if (fetch_req === 1'b1) begin
        n_tests++;
        if (execadd !== m_pc) begin
          n_fail++; $display("FAIL inc_seq execadd: got %h exp %h", execadd, m_pc);
        end
      end
    end
  endtask

  task automatic test_branch();
    bit taken = 0;
    clear_inputs(); imem_ready = 1'b1; branch_target = 19'h2A5C3;
    for (int i = 0; i < 16; i++) begin
      branch_req = (m_state == 2 && !taken);
      if (branch_req) taken = 1;
      step();
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL branch cyc %0d: got %h exp %h", i, obs_vec, exp_vec());
      end
      if (fetch_req === 1'b1) begin
        n_tests++;
        if (execadd !== m_pc) begin
          n_fail++; $display("FAIL branch execadd: got %h exp %h", execadd, m_pc);
        end
      end
    end
    branch_req = 1'b0;
  endtask

  task automatic test_halt_priority();
    int phase = 0;
    clear_inputs(); imem_ready = 1'b1; branch_target = WS'($urandom);
    for (int i = 0; i < 16; i++) begin
      halt_req = 1'b0; branch_req = 1'b0; start = 1'b0;
      if (m_state == 2 && phase == 0) begin
        halt_req = 1'b1; branch_req = 1'b1; phase = 1;
      end else if (m_state == 6 && phase == 1) begin
        start = 1'b1; phase = 2;
      end
      step();
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL halt cyc %0d: got %h exp %h", i, obs_vec, exp_vec());
      end
      if (fetch_req === 1'b1) begin
        n_tests++;
        if (execadd !== m_pc) begin
          n_fail++; $display("FAIL halt execadd: got %h exp %h", execadd, m_pc);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    int n_stall = 0;
    clear_inputs(); imem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      stall = (m_state == 2 && n_stall < 3);
      if (stall) n_stall++;
      step();
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL stall cyc %0d: got %h exp %h", i, obs_vec, exp_vec());
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_timeout();
    clear_inputs(); rst = 1'b1; step(); rst = 1'b0;
    start = 1'b1; imem_ready = 1'b0; step();
    for (int i = 0; i < 20; i++) begin
      start = 1'($urandom_range(0, 1));
      step();
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL timeout cyc %0d: got %h exp %h", i, obs_vec, exp_vec());
      end
    end
    n_tests++;
    if (fault !== 1'b1 || state_o !== 3'd7) begin
      n_fail++; $display("FAIL fault_sticky: got fault=%b state=%0d exp fault=1 state=7", fault, state_o);
    end
    start = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    n_tests++;
    if (fault !== 1'b0 || state_o !== 3'd0) begin
      n_fail++; $display("FAIL fault_clear: got fault=%b state=%0d exp fault=0 state=0", fault, state_o);
    end
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL late_ready cyc %0d: got %h exp %h", i, obs_vec, exp_vec());
      end
    end
    imem_ready = 1'b1; step();
    n_tests++;
    if (state_o !== 3'd2 || fault !== 1'b0) begin
      n_fail++; $display("FAIL ready_on_last: got state=%0d fault=%b exp state=2 fault=0", state_o, fault);
    end
  endtask

  task automatic test_reset_mid();
    bit done = 0;
    clear_inputs(); imem_ready = 1'b1; branch_target = WS'($urandom) | 19'h1;
    for (int i = 0; i < 20; i++) begin
      branch_req = (m_state == 2);
      rst = 1'b0; start = 1'b0;
      if (m_state == 4 && !done) begin rst = 1'b1; done = 1; end
      else if (m_state == 0) start = 1'b1;
      step();
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL reset_mid cyc %0d: got %h exp %h", i, obs_vec, exp_vec());
      end
      if (rst) begin
        n_tests++;
        if (address !== '0 || {load_pc, inc_pc} !== 2'b00 || fetch_req !== 1'b0) begin
          n_fail++; $display("FAIL reset_mid_outputs: got addr=%h cmd=%b fetch=%b exp 0/00/0",
                             address, {load_pc, inc_pc}, fetch_req);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      start         = ($urandom_range(0, 3) == 0);
      halt_req      = ($urandom_range(0, 7) == 0);
      branch_req    = ($urandom_range(0, 3) == 0);
      stall         = ($urandom_range(0, 2) == 0);
      imem_ready    = ($urandom_range(0, 3) != 0);
      branch_target = WS'($urandom);
      step();
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h exp %h", i, obs_vec, exp_vec());
      end
      if (fetch_req === 1'b1) begin
        n_tests++;
        if (execadd !== m_pc) begin
          n_fail++; $display("FAIL random execadd: got %h exp %h", execadd, m_pc);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_inc_sequence();
    test_branch();
    test_halt_priority();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control-side FSM that drives the program counter's LOAD_PC / INC_PC command pair and its 19-bit ADDRESS load value.
- Sequences instruction fetch:
  - issues a fetch request;
  - waits for instruction-memory ready;
  - decides whether to increment, branch, stall or halt;
  - waits for the PC's registered output (execadd) to settle before the next fetch.
- Sits between decode/branch logic and the PC, on the driving end of the control_bus_if PC signals.

Parameters:
- WORD_SIZE, 19, width of ADDRESS and BRANCH_TARGET.
- MEM_TIMEOUT, 15, number of FETCH cycles with IMEM_READY low before FAULT (must be ≥1).
- CNT_W, 4, width of the timeout counter (must hold MEM_TIMEOUT).

Ports:
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  synchronous reset, active-high.
- START  input  1  begin fetching from IDLE, or resume from HALTED.
- HALT_REQ  input  1  halt request, sampled in DECIDE.
- BRANCH_REQ  input  1  branch taken, sampled in DECIDE.
- BRANCH_TARGET  input  WORD_SIZE  branch destination, sampled in DECIDE.
- STALL  input  1  hold in DECIDE while high.
- IMEM_READY  input  1  instruction memory has returned the word at execadd.
- LOAD_PC  output  1  PC command bit.
- INC_PC  output  1  PC command bit.
- ADDRESS  output  WORD_SIZE  PC load value.
- FETCH_REQ  output  1  instruction fetch request.
- HALTED  output  1  high in HALTED state.
- FAULT  output  1  high in FAULT state (sticky until RST).
- STATE_O  output  3  current state encoding, for debug.

Behaviour:
- PC command encoding {LOAD_PC, INC_PC}:
  - 00 = CLEAR (PC temp to 0)
  - 10 = LOAD (temp to ADDRESS)
  - 01 = INC (temp + 1)
  - 11 = HOLD
- The PC's execadd lags temp by one cycle.
- All outputs are registered Moore outputs of the state, valid in the cycle the FSM occupies that state.
- States and STATE_O encoding: IDLE=0, FETCH=1, DECIDE=2, ISSUE_INC=3, ISSUE_LOAD=4, SETTLE=5, HALTED=6, FAULT=7.
- Command per state: IDLE=CLEAR; ISSUE_INC=INC; ISSUE_LOAD=LOAD; all other states=HOLD. FETCH_REQ=1 only in FETCH.
- Reset: state IDLE, {LOAD_PC, INC_PC}=00, ADDRESS=0, FETCH_REQ=0, HALTED=0, FAULT=0, counter=0. RST asserted mid-operation gives the same values on the following edge; no pending branch survives.
- IDLE: START=1 → FETCH; otherwise stay.
- FETCH:
  - counter cleared on entry, increments each cycle IMEM_READY=0.
  - IMEM_READY=1 → DECIDE; this wins over timeout in the same cycle.
  - counter reaching MEM_TIMEOUT with IMEM_READY=0 → FAULT (i.e. MEM_TIMEOUT FETCH cycles without ready).
  - START ignored.
- DECIDE priority:
  - HALT_REQ → HALTED
  - else BRANCH_REQ → ISSUE_LOAD, ADDRESS <= BRANCH_TARGET on that edge
  - else STALL → stay DECIDE
  - else → ISSUE_INC
- ISSUE_INC / ISSUE_LOAD: one cycle each → SETTLE.
- ADDRESS holds its last value at all other times; it changes only on a taken branch or RST.
- SETTLE: one cycle → FETCH. This guarantees execadd reflects the new PC when FETCH_REQ rises: DECIDE at t, ISSUE at t+1, SETTLE at t+2, FETCH at t+3.
- HALTED: HOLD; HALTED=1; START=1 → FETCH (resume at the current PC, no increment).
- FAULT: HOLD; FAULT=1; leaves only on RST.
- The FSM never drives CLEAR after leaving IDLE, except via RST.
- The FSM never drives both LOAD and INC semantics in the same cycle.

Test Plan:
- RST 2 cycles, then START pulse, IMEM_READY tied 1 → state sequence 0,1,2,3,5,1,...; INC_PC=1/LOAD_PC=0 exactly in state 3; PC execadd steps 0,1,2 on successive fetches.
- In DECIDE: BRANCH_REQ=1, BRANCH_TARGET=19'h2A5C3 → next cycle LOAD_PC=1, INC_PC=0, ADDRESS=19'h2A5C3; next FETCH_REQ sees execadd=19'h2A5C3; ADDRESS unchanged after the following increment.
- HALT_REQ=1 and BRANCH_REQ=1 together in DECIDE → HALTED=1, ADDRESS unchanged, command 11; START one cycle later → FETCH with PC unchanged.
- STALL=1 for 3 cycles in DECIDE → 3 extra DECIDE cycles with command 11, then ISSUE_INC.
- IMEM_READY=0 for 15 FETCH cycles → FAULT=1, STATE_O=7, stays through START; ready on cycle 15 instead → DECIDE, no fault; RST → IDLE, FAULT=0.
- RST asserted during ISSUE_LOAD → next cycle state IDLE, outputs 00, ADDRESS=0, FETCH_REQ=0.
